// File: rtl/cfa_pkg.sv
// Shared definitions for the CFA demosaic datapath: interpolation mode
// encodings, the edge-direction code and the unsigned output clamp.
package cfa_pkg;

  typedef enum logic [1:0] {
    CFA_MODE_AVG   = 2'd0,
    CFA_MODE_CDIFF = 2'd1,
    CFA_MODE_EDGE  = 2'd2,
    CFA_MODE_RSVD  = 2'd3
  } cfa_mode_e;

  typedef enum logic [1:0] {
    CFA_DIR_A   = 2'd0,
    CFA_DIR_B   = 2'd1,
    CFA_DIR_TIE = 2'd2
  } cfa_dir_e;

  // Saturate a signed value into the unsigned range [0, 2^w-1] (w < 32).
  function automatic logic [31:0] clamp_u(input logic signed [31:0] x, input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    if (x < 0) return '0;
    if ($unsigned(x) > lim) return lim;
    return $unsigned(x);
  endfunction

endpackage

// File: rtl/rb_diag_lane.sv
// One lane of the R-at-B / B-at-R diagonal interpolator: a 3-stage datapath
// (sums/gradients, mode select, round+clamp) that advances only when en=1.
module rb_diag_lane
  import cfa_pkg::*;
#(
  parameter int DataBitWidth = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [DataBitWidth-1:0]   g_c,
  input  logic [4*DataBitWidth-1:0] g_diag,
  input  logic [4*DataBitWidth-1:0] rb_diag,
  output logic [DataBitWidth-1:0]   rb
);

  localparam int W  = DataBitWidth;
  localparam int AW = DataBitWidth + 4;

  function automatic logic signed [AW-1:0] ext(input logic [W-1:0] x);
    return $signed({4'b0000, x});
  endfunction

  function automatic logic signed [AW-1:0] absd(input logic signed [AW-1:0] a,
                                                 input logic signed [AW-1:0] b);
    logic signed [AW-1:0] d;
    d = a - b;
    return (d < 0) ? -d : d;
  endfunction

  // Rounding offset is pre-added in S1; this is the final floor shift.
  function automatic logic signed [AW-1:0] rnd_shr(input logic signed [AW-1:0] num,
                                                    input logic                  half);
    return half ? (num >>> 1) : (num >>> 2);
  endfunction

  logic signed [AW-1:0] g [4];
  logic signed [AW-1:0] r [4];
  logic signed [AW-1:0] sum_g, sum_rb, grad_a, grad_b;

  // Unpack diagonals: index 0=mm, 1=mp, 2=pm, 3=pp; A pair is {0,3}, B pair {1,2}
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      g[i] = ext(g_diag[i*W +: W]);
      r[i] = ext(rb_diag[i*W +: W]);
    end
  end

  assign sum_g  = g[0] + g[1] + g[2] + g[3];
  assign sum_rb = r[0] + r[1] + r[2] + r[3];
  assign grad_a = absd(r[0], r[3]);
  assign grad_b = absd(r[1], r[2]);

  // ---- S1: sums, colour differences and gradient direction ----
  logic signed [AW-1:0] avg_num_p0, cd_num_p0, a_num_p0, b_num_p0, gc_p0;
  cfa_mode_e            mode_p0;
  cfa_dir_e             dir_p0;

  // Register per-mode numerators (rounding offsets included) and direction
  always_ff @(posedge clk) begin
    if (en) begin
      avg_num_p0 <= sum_rb + AW'(2);
      cd_num_p0  <= sum_rb - sum_g + AW'(2);
      a_num_p0   <= r[0] + r[3] - g[0] - g[3] + AW'(1);
      b_num_p0   <= r[1] + r[2] - g[1] - g[2] + AW'(1);
      gc_p0      <= ext(g_c);
      mode_p0    <= cfa_mode_e'(mode);
      dir_p0     <= (grad_a < grad_b) ? CFA_DIR_A :
                    (grad_b < grad_a) ? CFA_DIR_B : CFA_DIR_TIE;
    end
  end

  // ---- S2: select numerator, shift and whether G_c is added ----
  logic signed [AW-1:0] num_s2;
  logic                 half_s2, add_gc_s2;

  // Mode/direction select; reserved mode falls back to colour difference
  always_comb begin
    num_s2    = cd_num_p0;
    half_s2   = 1'b0;
    add_gc_s2 = 1'b1;
    case (mode_p0)
      CFA_MODE_AVG: begin
        num_s2    = avg_num_p0;
        add_gc_s2 = 1'b0;
      end
      CFA_MODE_EDGE: begin
        case (dir_p0)
          CFA_DIR_A: begin
            num_s2  = a_num_p0;
            half_s2 = 1'b1;
          end
          CFA_DIR_B: begin
            num_s2  = b_num_p0;
            half_s2 = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  logic signed [AW-1:0] num_p1, gc_p1;
  logic                 half_p1, add_gc_p1;

  // Register the selected operands
  always_ff @(posedge clk) begin
    if (en) begin
      num_p1    <= num_s2;
      half_p1   <= half_s2;
      add_gc_p1 <= add_gc_s2;
      gc_p1     <= gc_p0;
    end
  end

  // ---- S3: round, add centre green, clamp into the output register ----
  logic signed [AW-1:0] res_s3;
  logic [W-1:0]         rb_p2;

  assign res_s3 = (add_gc_p1 ? gc_p1 : '0) + rnd_shr(num_p1, half_p1);

  // Output register is cleared by reset so RB reads 0 after reset
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_p2 <= '0;
    end else if (en) begin
      rb_p2 <= W'(clamp_u(32'(res_s3), W));
    end
  end

  assign rb = rb_p2;

endmodule

// File: rtl/rb_diag_interp_pipe.sv
// Multi-lane diagonal R/B interpolator: owns the valid chain, the global
// advance enable (also in_ready) and the lane packing.
module rb_diag_interp_pipe
  import cfa_pkg::*;
#(
  parameter int DataBitWidth = 12,
  parameter int N_LANES      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [1:0]                        in_mode,
  input  logic [N_LANES*DataBitWidth-1:0]   G_c,
  input  logic [N_LANES*4*DataBitWidth-1:0] G_diag,
  input  logic [N_LANES*4*DataBitWidth-1:0] RB_diag,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [N_LANES*DataBitWidth-1:0]   RB
);

  localparam int W = DataBitWidth;

  logic en;
  logic vld_p0, vld_p1, vld_p2;

  // Whole pipe advances together; it only stalls when the output is held
  assign en        = !vld_p2 || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_p2;

  // Valid chain; reset discards every in-flight beat
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    rb_diag_lane #(
      .DataBitWidth(DataBitWidth)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .mode    (in_mode),
      .g_c     (G_c[k*W +: W]),
      .g_diag  (G_diag[k*4*W +: 4*W]),
      .rb_diag (RB_diag[k*4*W +: 4*W]),
      .rb      (RB[k*W +: W])
    );
  end

endmodule

// File: tb/tb_rb_diag_interp_pipe.sv
// Directed + scoreboard bench for rb_diag_interp_pipe (W=12, 2 lanes).
module tb_rb_diag_interp_pipe;

  localparam int W = 12;
  localparam int N = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       in_mode = 2'd0;
  logic [N*W-1:0]   G_c = '0;
  logic [N*4*W-1:0] G_diag = '0;
  logic [N*4*W-1:0] RB_diag = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N*W-1:0]   RB;

  always #5 clk = ~clk;

  rb_diag_interp_pipe #(.DataBitWidth(W), .N_LANES(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .G_c       (G_c),
    .G_diag    (G_diag),
    .RB_diag   (RB_diag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .RB        (RB)
  );

  int             n_cmp = 0;
  int             n_err = 0;
  int             n_emit = 0;
  logic [N*W-1:0] sb [$];
  logic           last_acc = 1'b0, last_emit = 1'b0, last_ov = 1'b0, last_ir = 1'b0;
  logic [N*W-1:0] last_rb = '0;
  logic           stalled_prev = 1'b0;
  logic [N*W-1:0] stall_rb = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model written straight from the interpolation formulas
  function automatic logic [W-1:0] ref_lane(input logic [1:0] m, input logic [W-1:0] gc,
                                            input logic [4*W-1:0] gd, input logic [4*W-1:0] rd);
    int g [4];
    int r [4];
    int gci, sg, sr, ga, gb, res;
    for (int i = 0; i < 4; i++) begin
      g[i] = int'(gd[i*W +: W]);
      r[i] = int'(rd[i*W +: W]);
    end
    gci = int'(gc);
    sg  = g[0] + g[1] + g[2] + g[3];
    sr  = r[0] + r[1] + r[2] + r[3];
    ga  = r[0] - r[3]; if (ga < 0) ga = -ga;
    gb  = r[1] - r[2]; if (gb < 0) gb = -gb;
    case (m)
      2'd0: res = (sr + 2) >>> 2;
      2'd2: begin
        if (ga < gb)      res = gci + ((r[0] + r[3] - g[0] - g[3] + 1) >>> 1);
        else if (gb < ga) res = gci + ((r[1] + r[2] - g[1] - g[2] + 1) >>> 1);
        else              res = gci + ((sr - sg + 2) >>> 2);
      end
      default: res = gci + ((sr - sg + 2) >>> 2);
    endcase
    if (res < 0) res = 0;
    if (res > 4095) res = 4095;
    return W'(res);
  endfunction

  function automatic logic [N*W-1:0] ref_beat();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = ref_lane(in_mode, G_c[k*W +: W], G_diag[k*4*W +: 4*W], RB_diag[k*4*W +: 4*W]);
    return v;
  endfunction

  task automatic set_lane(input int k, input logic [W-1:0] gc,
                          input logic [W-1:0] gmm, input logic [W-1:0] gmp,
                          input logic [W-1:0] gpm, input logic [W-1:0] gpp,
                          input logic [W-1:0] rmm, input logic [W-1:0] rmp,
                          input logic [W-1:0] rpm, input logic [W-1:0] rpp);
    G_c[k*W +: W]           = gc;
    G_diag[k*4*W + 0*W +: W]  = gmm;
    G_diag[k*4*W + 1*W +: W]  = gmp;
    G_diag[k*4*W + 2*W +: W]  = gpm;
    G_diag[k*4*W + 3*W +: W]  = gpp;
    RB_diag[k*4*W + 0*W +: W] = rmm;
    RB_diag[k*4*W + 1*W +: W] = rmp;
    RB_diag[k*4*W + 2*W +: W] = rpm;
    RB_diag[k*4*W + 3*W +: W] = rpp;
  endtask

  // One clock: sample at negedge, scoreboard the handshakes, return just after posedge
  task automatic cyc();
    @(negedge clk);
    last_ov   = out_valid;
    last_ir   = in_ready;
    last_rb   = RB;
    last_acc  = 1'b0;
    last_emit = 1'b0;
    if (!rst) begin
      if (stalled_prev) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_rb", RB, stall_rb);
      end
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid && out_ready) begin
        last_emit = 1'b1;
        n_emit++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $error("FAIL unexpected_out: observed %0d expected no beat", RB);
        end else begin
          chk("sb_rb", RB, sb.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_beat());
        last_acc = 1'b1;
      end
      stalled_prev = out_valid && !out_ready;
      stall_rb     = RB;
    end else begin
      stalled_prev = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_emit(input string tag, input logic [N*W-1:0] exp);
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (last_emit) break;
    end
    if (!last_emit) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_timeout: observed no output expected %0d", tag, exp);
    end else begin
      chk(tag, last_rb, exp);
    end
  endtask

  task automatic send_one(input logic [1:0] m);
    in_mode  = m;
    in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (sb.size() == 0) break;
      cyc();
    end
    chk("drained", sb.size(), 0);
  endtask

  initial begin
    int idx, c, em0;
    logic any_ov;

    // Reset
    repeat (3) cyc();
    rst = 1'b0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_rb", RB, 0);
    chk("reset_in_ready", in_ready, 1);

    // 1: AVG, latency 3
    set_lane(0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd100, 12'd100, 12'd100, 12'd100);
    set_lane(1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd100, 12'd100, 12'd100, 12'd100);
    send_one(2'd0);
    chk("avg_accept", last_acc, 1);
    cyc(); chk("avg_lat_c1", last_ov, 0);
    cyc(); chk("avg_lat_c2", last_ov, 0);
    cyc(); chk("avg_lat_c3", last_ov, 1);
    chk("avg_rb", last_rb, {12'd100, 12'd100});

    // 2: CDIFF nominal, then clamp high (lane 0) / clamp low (lane 1)
    set_lane(0, 12'd200, 12'd100, 12'd100, 12'd100, 12'd100, 12'd150, 12'd150, 12'd150, 12'd150);
    set_lane(1, 12'd200, 12'd100, 12'd100, 12'd100, 12'd100, 12'd150, 12'd150, 12'd150, 12'd150);
    send_one(2'd1);
    wait_emit("cdiff_rb", {12'd250, 12'd250});
    send_one(2'd3);
    wait_emit("rsvd_as_cdiff", {12'd250, 12'd250});
    set_lane(0, 12'd4000, 12'd0, 12'd0, 12'd0, 12'd0, 12'd4095, 12'd4095, 12'd4095, 12'd4095);
    set_lane(1, 12'd0, 12'd1000, 12'd1000, 12'd1000, 12'd1000, 12'd0, 12'd0, 12'd0, 12'd0);
    send_one(2'd1);
    wait_emit("cdiff_clamp", {12'd0, 12'd4095});

    // 3: EDGE A pair (lane 0) and B pair (lane 1), then a gradient tie
    set_lane(0, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd0, 12'd400, 12'd120);
    set_lane(1, 12'd300, 12'd100, 12'd100, 12'd100, 12'd100, 12'd0, 12'd100, 12'd120, 12'd400);
    send_one(2'd2);
    wait_emit("edge_pairs", {12'd310, 12'd110});
    set_lane(0, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd120, 12'd120);
    set_lane(1, 12'd500, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd100, 12'd120, 12'd120);
    send_one(2'd2);
    wait_emit("edge_tie", {12'd510, 12'd110});
    send_one(2'd1);
    wait_emit("tie_cdiff_ref", {12'd510, 12'd110});

    // 4: 20-beat stream with a 5-cycle output stall
    em0      = n_emit;
    idx      = 0;
    c        = 0;
    in_mode  = 2'd1;
    in_valid = 1'b1;
    while (idx < 20 && c < 100) begin
      for (int k = 0; k < N; k++)
        set_lane(k, 12'(10*idx + k), 12'(7*idx), 12'(7*idx + 1), 12'(7*idx + 2), 12'(7*idx + 3),
                 12'(50 + 13*idx + k), 12'(53 + 13*idx), 12'(56 + 13*idx), 12'(59 + 13*idx + k));
      out_ready = !(c >= 8 && c < 13);
      cyc();
      if (!out_ready) chk("bp_in_ready_low", last_ir, 0);
      if (last_acc) idx++;
      c++;
    end
    drain();
    chk("bp_count", n_emit - em0, 20);

    // 5: alternate AVG/EDGE every beat at full rate
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_mode = (i % 2 == 1) ? 2'd2 : 2'd0;
      for (int k = 0; k < N; k++)
        set_lane(k, 12'($urandom_range(4095)),
                 12'($urandom_range(4095)), 12'($urandom_range(4095)),
                 12'($urandom_range(4095)), 12'($urandom_range(4095)),
                 12'($urandom_range(4095)), 12'($urandom_range(4095)),
                 12'($urandom_range(4095)), 12'($urandom_range(4095)));
      cyc();
      chk("ms_accept", last_acc, 1);
      if (i >= 3) chk("ms_throughput", last_emit, 1);
    end
    drain();

    // 6: reset with 3 beats in flight
    in_mode = 2'd0;
    in_valid = 1'b1;
    repeat (3) cyc();
    in_valid = 1'b0;
    rst = 1'b1;
    cyc();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_rb", RB, 0);
    chk("midrst_in_ready", in_ready, 1);
    sb.delete();
    rst = 1'b0;
    any_ov = 1'b0;
    repeat (6) begin
      cyc();
      any_ov = any_ov | last_ov;
    end
    chk("midrst_no_stale", any_ov, 0);
    set_lane(0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd100, 12'd100, 12'd100, 12'd100);
    set_lane(1, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0, 12'd40, 12'd41, 12'd42, 12'd43);
    send_one(2'd0);
    wait_emit("post_rst_avg", {12'd42, 12'd100});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
